// File: rtl/sad_lane_writer.sv
// sad_lane_writer -- producer side of the 32-lane SAD input FIFO bank.
//
// Takes a byte-serial pixel stream (valid/ready), stages one row of LANES
// bytes, then fires a single shared write strobe that loads every lane FIFO
// in parallel. Byte j of a row lands in lane j, so an interleaved stream
// (cur0, ref0, cur1, ref1, ...) puts current pixel k on lane 2k and its
// reference pixel on lane 2k+1. Exactly ROWS rows are written per block.
//
// Optional build macro: SAD_LANE_WRITER_DBUF_EN
//   Adds a second staging bank per lane. A completed row is promoted to the
//   output bank, and filling continues into the fill bank while the output
//   bank waits for its write, so a stream can sustain one row per LANES cycles.
//
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-low reset
//   start        one-cycle pulse that begins a block (ignored while busy)
//   pix_in       pixel byte
//   pix_valid    pix_in valid this cycle
//   pix_ready    block accepts pix_in this cycle
//   full_vec     per-lane FIFO full flags
//   wr           shared FIFO write strobe
//   lane_data    lane n data on bits [DW*n +: DW]
//   busy         high from start acceptance until block_done
//   block_done   one-cycle pulse after the last row's write
//   row_cnt      rows written in the current block

// Per-lane staging: one fill register, plus an output register in the
// double-buffered build.
module sad_lane_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fill,
`ifdef SAD_LANE_WRITER_DBUF_EN
  input  logic          promote,
`endif
  input  logic [DW-1:0] pix,
  output logic [DW-1:0] data
);
  logic [DW-1:0] stage_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      stage_q <= '0;
    else if (fill) stage_q <= pix;
  end

`ifdef SAD_LANE_WRITER_DBUF_EN
  logic [DW-1:0] out_q;

  // The lane whose byte arrives on the promoting edge (the row's last byte)
  // takes it straight from the input rather than from the fill register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         out_q <= '0;
    else if (promote) out_q <= fill ? pix : stage_q;
  end

  assign data = out_q;
`else
  assign data = stage_q;
`endif
endmodule

module sad_lane_writer #(
  parameter int LANES = 32,
  parameter int DW    = 8,
  parameter int ROWS  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DW-1:0]       pix_in,
  input  logic                pix_valid,
  output logic                pix_ready,
  input  logic [LANES-1:0]    full_vec,
  output logic                wr,
  output logic [LANES*DW-1:0] lane_data,
  output logic                busy,
  output logic                block_done,
  output logic [4:0]          row_cnt
);
  localparam int IW = $clog2(LANES);

  typedef enum logic [1:0] {IDLE, LOAD, ISSUE, DONE} state_t;

  state_t                    state, state_nxt;
  logic [IW-1:0]             byte_idx;
  logic                      xfer, last_byte, row_fill, last_row, promote;
  logic [LANES-1:0]          fill;
  logic [LANES-1:0][DW-1:0]  lane_q;

  assign xfer      = pix_valid & pix_ready;
  assign last_byte = (byte_idx == IW'(LANES - 1));
  assign row_fill  = xfer & last_byte;
  assign last_row  = (row_cnt == 5'(ROWS - 1));

  // All outputs decode from registered state, so an async reset clears
  // them immediately, including a write strobe that is mid-ISSUE.
  assign busy       = (state == LOAD) | (state == ISSUE);
  assign block_done = (state == DONE);
  assign wr         = (state == ISSUE) & ~|full_vec;

`ifdef SAD_LANE_WRITER_DBUF_EN
  logic       stg_full;
  logic [4:0] rows_staged;

  // Stall only when the fill bank holds a complete row that the output bank
  // cannot take yet, or once the whole block has been staged.
  assign pix_ready = busy & ~stg_full & (rows_staged != 5'(ROWS));

  // The output bank is free when idle in LOAD or when it is written this
  // cycle; a ready row (waiting or just completing) moves into it then.
  assign promote = ((state == LOAD) | wr) & (stg_full | row_fill);
`else
  assign pix_ready = (state == LOAD);
  assign promote   = (state == LOAD) & row_fill;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (promote) state_nxt = ISSUE;
      ISSUE: begin
        // No partial writes: the row stays put until every lane has room.
        if (wr) begin
          if (last_row)     state_nxt = DONE;
          else if (promote) state_nxt = ISSUE;
          else              state_nxt = LOAD;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      byte_idx <= '0;
      row_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && start) begin
        byte_idx <= '0;
        row_cnt  <= '0;
      end else begin
        if (xfer) byte_idx <= last_byte ? '0 : byte_idx + 1'b1;
        if (wr)   row_cnt  <= row_cnt + 5'd1;
      end
    end
  end

`ifdef SAD_LANE_WRITER_DBUF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stg_full    <= 1'b0;
      rows_staged <= '0;
    end else if ((state == IDLE) && start) begin
      stg_full    <= 1'b0;
      rows_staged <= '0;
    end else begin
      if (row_fill) rows_staged <= rows_staged + 5'd1;
      if (row_fill && !promote)      stg_full <= 1'b1;
      else if (promote && stg_full)  stg_full <= 1'b0;
    end
  end
`endif

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    assign fill[j] = xfer & (byte_idx == IW'(j));

    sad_lane_stage #(.DW(DW)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .fill    (fill[j]),
`ifdef SAD_LANE_WRITER_DBUF_EN
      .promote (promote),
`endif
      .pix     (pix_in),
      .data    (lane_q[j])
    );
  end

  assign lane_data = lane_q;
endmodule

// File: tb/tb_sad_lane_writer.sv
`timescale 1ns/1ps
module tb_sad_lane_writer;
  localparam int LANES = 32, DW = 8, ROWS = 16, W = LANES * DW;
`ifdef SAD_LANE_WRITER_DBUF_EN
  localparam int DBUF = 1, BASE = 32;
`else
  localparam int DBUF = 0, BASE = 33;
`endif

  logic           clk = 1'b0, rst = 1'b0, start = 1'b0, pix_valid = 1'b0;
  logic [DW-1:0]  pix_in = '0;
  logic [LANES-1:0] full_vec = '0;
  logic           pix_ready, wr, busy, block_done;
  logic [W-1:0]   lane_data;
  logic [4:0]     row_cnt;

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  sad_lane_writer #(.LANES(LANES), .DW(DW), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .full_vec(full_vec), .wr(wr), .lane_data(lane_data),
    .busy(busy), .block_done(block_done), .row_cnt(row_cnt)
  );

  typedef struct {
    string name;
    int    gap;        // 1: pix_valid only on odd cycles
    int    bp_row;     // row held off by full_vec[31], -1 none
    int    bp_len;
    int    bs_row;     // row during which a stray start pulses, -1 none
    int    abort_at;   // reset after this many bytes, 0 none
    int    exp_writes;
    int    exp_first;  // cycles from start to first wr
    int    exp_period; // nominal cycles between writes
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [W-1:0] row_exp(input int r);
    logic [W-1:0] v;
    for (int n = 0; n < LANES; n++) v[n*DW +: DW] = DW'((r * LANES + n) % 256);
    return v;
  endfunction

  function automatic int exp_per(input vec_t v, input int r);
    int p;
    p = v.exp_period;
    if (r == v.bp_row) p += v.bp_len;
    // With two banks the next row keeps filling during the stall.
    if (DBUF == 1 && r == v.bp_row + 1) p -= v.bp_len;
    return p;
  endfunction

  task automatic run_vec(input vec_t v);
    int sent = 0, nwr = 0, ndone = 0, first_wr = -1, last_wr = 0, bp_left = 0;
    bit bp_done = 0, bs_done = 0, ended = 0;
    @(posedge clk); #1;
    for (int it = 0; it < 3000 && !ended; it++) begin
      start = (it == 0);
      if (v.bs_row >= 0 && !bs_done && nwr == v.bs_row && sent == v.bs_row * LANES + 3) begin
        start = 1'b1; bs_done = 1;
      end
      if (v.bp_row >= 0 && !bp_done && nwr == v.bp_row && sent == (v.bp_row + 1) * LANES) begin
        bp_left = v.bp_len; bp_done = 1;
      end
      full_vec  = (bp_left > 0) ? {1'b1, {(LANES-1){1'b0}}} : '0;
      pix_valid = (sent < ROWS * LANES) && (v.gap == 0 || (it % 2) == 1);
      pix_in    = DW'(sent % 256);
      #1;
      if (bp_left > 0) begin
        check({v.name, " stall wr"}, W'(wr), W'(0));
        check({v.name, " stall data"}, lane_data, row_exp(v.bp_row));
        bp_left--;
      end
      if (wr) begin
        check({v.name, " row data"}, lane_data, row_exp(nwr));
        check({v.name, " row_cnt at wr"}, W'(row_cnt), W'(nwr));
        if (nwr == 0) first_wr = it;
        else check({v.name, " wr period"}, W'(it - last_wr), W'(exp_per(v, nwr)));
        last_wr = it;
        nwr++;
      end
      if (block_done) begin ndone++; ended = 1; end
      if (pix_valid && pix_ready) sent++;
      if (v.abort_at > 0 && sent == v.abort_at) ended = 1;
      @(posedge clk); #1;
    end
    start = 1'b0; pix_valid = 1'b0; full_vec = '0;
    if (v.abort_at > 0) begin
      #1 rst = 1'b0;
      #1;
      check({v.name, " rst wr"},        W'(wr),        W'(0));
      check({v.name, " rst busy"},      W'(busy),      W'(0));
      check({v.name, " rst pix_ready"}, W'(pix_ready), W'(0));
      check({v.name, " rst row_cnt"},   W'(row_cnt),   W'(0));
      check({v.name, " rst lane_data"}, lane_data,     W'(0));
      #1 rst = 1'b1;
    end else begin
      check({v.name, " end busy"},    W'(busy),       W'(0));
      check({v.name, " end row_cnt"}, W'(row_cnt),    W'(ROWS));
      check({v.name, " end done"},    W'(block_done), W'(0));
    end
    check({v.name, " writes"},   W'(nwr),      W'(v.exp_writes));
    check({v.name, " done cnt"}, W'(ndone),    W'((v.abort_at > 0) ? 0 : 1));
    check({v.name, " first wr"}, W'(first_wr), W'(v.exp_first));
  endtask

  initial begin
    int sent;
    vecs[0] = '{"plain",      0, -1,  0, -1,  0, 16, 33, BASE};
    vecs[1] = '{"gaps",       1, -1,  0, -1,  0, 16, 64, 64};
    vecs[2] = '{"backpress",  0,  3, 10, -1,  0, 16, 33, BASE};
    vecs[3] = '{"abort",      0, -1,  0, -1, 82,  2, 33, BASE};
    vecs[4] = '{"busy_start", 0, -1,  0,  5,  0, 16, 33, BASE};

    // Reset state, then idle without start.
    repeat (3) @(posedge clk);
    #1;
    check("reset pix_ready",  W'(pix_ready),  W'(0));
    check("reset wr",         W'(wr),         W'(0));
    check("reset busy",       W'(busy),       W'(0));
    check("reset block_done", W'(block_done), W'(0));
    check("reset row_cnt",    W'(row_cnt),    W'(0));
    check("reset lane_data",  lane_data,      W'(0));
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle pix_ready", W'(pix_ready), W'(0));
    check("idle wr",        W'(wr),        W'(0));
    check("idle busy",      W'(busy),      W'(0));

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Full flags honoured combinationally; reset during ISSUE drops wr.
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; pix_valid = 1'b1; sent = 0;
    for (int i = 0; i < 100 && sent < LANES; i++) begin
      pix_in = DW'(sent);
      #1;
      if (pix_ready) sent++;
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    check("seq bytes sent", W'(sent), W'(LANES));
    full_vec = '1;
    #1 check("seq all full wr", W'(wr), W'(0));
    full_vec = {{(LANES-1){1'b0}}, 1'b1};
    #1 check("seq lane0 full wr", W'(wr), W'(0));
    full_vec = '0;
    #1 check("seq full clear wr", W'(wr), W'(1));
    check("seq issue data", lane_data, row_exp(0));
    rst = 1'b0;
    #1;
    check("seq rst in issue wr", W'(wr),   W'(0));
    check("seq rst in issue busy", W'(busy), W'(0));
    check("seq rst in issue data", lane_data, W'(0));
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
